// File: rtl/axis_traffic_sink.sv
// AXI-Stream sink/checker: drives tready with a selectable backpressure pattern,
// checks accepted beats against an incrementing sequence and reports pass/fail.
module axis_traffic_sink #(
  parameter int                    DATA_WIDTH = 64,
  parameter int                    NUM_BEATS  = 16,
  parameter logic [DATA_WIDTH-1:0] SEED       = '0,
  parameter int                    CNT_WIDTH  = 32,
  parameter int                    TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            bp_mode,
  input  logic [DATA_WIDTH-1:0] axis_tdata,
  input  logic                  axis_tvalid,
  output logic                  axis_tready,
  output logic [CNT_WIDTH-1:0]  beat_count,
  output logic [CNT_WIDTH-1:0]  error_count,
  output logic [CNT_WIDTH-1:0]  first_err_idx,
  output logic [DATA_WIDTH-1:0] first_err_data,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic                  pass
);

  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] expected;
  logic [15:0]           lfsr, lfsr_adv;
  logic [1:0]            phase;
  logic                  alt;
  logic [WD_W-1:0]       wd;
  logic                  hs, mismatch, last_beat, wd_expire, run_entry;
  logic                  bp_entry, bp_run;

  assign hs        = (state == RUN) && axis_tvalid && axis_tready;
  assign mismatch  = hs && (axis_tdata != expected);
  assign last_beat = hs && (beat_count == CNT_WIDTH'(NUM_BEATS - 1));
  assign wd_expire = (state == RUN) && !hs && (wd == WD_W'(TIMEOUT - 1));
  assign run_entry = (state != RUN) && start;

  // Taps 16,14,13,11 in right-shift Fibonacci form
  assign lfsr_adv = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_beat || wd_expire) state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Ready for the first RUN cycle (entry) and for each following RUN cycle
  always_comb begin
    bp_entry = 1'b1;
    bp_run   = 1'b1;
    case (bp_mode)
      2'b01: begin bp_entry = 1'b1;          bp_run = ~alt;                 end
      2'b10: begin bp_entry = lfsr[0];       bp_run = lfsr_adv[0];          end
      2'b11: begin bp_entry = (phase == '0); bp_run = (phase + 2'd1) == '0; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      axis_tready    <= 1'b0;
      beat_count     <= '0;
      error_count    <= '0;
      first_err_idx  <= '0;
      first_err_data <= '0;
      timeout        <= 1'b0;
      pass           <= 1'b0;
      expected       <= SEED;
      lfsr           <= 16'hACE1;
      phase          <= '0;
      alt            <= 1'b0;
      wd             <= '0;
    end else if (run_entry) begin
      axis_tready    <= bp_entry;
      beat_count     <= '0;
      error_count    <= '0;
      first_err_idx  <= '0;
      first_err_data <= '0;
      timeout        <= 1'b0;
      pass           <= 1'b0;
      expected       <= SEED;
      alt            <= 1'b1;
      wd             <= '0;
    end else if (state == RUN) begin
      lfsr  <= lfsr_adv;
      phase <= phase + 2'd1;
      alt   <= ~alt;
      axis_tready <= (last_beat || wd_expire) ? 1'b0 : bp_run;
      if (hs) begin
        wd         <= '0;
        expected   <= expected + 1'b1;
        beat_count <= (&beat_count) ? beat_count : beat_count + 1'b1;
        if (mismatch) begin
          error_count <= (&error_count) ? error_count : error_count + 1'b1;
          // error_count never wraps, so zero means no mismatch yet this run
          if (error_count == '0) begin
            first_err_idx  <= beat_count;
            first_err_data <= axis_tdata;
          end
        end
      end else begin
        wd <= wd + 1'b1;
        if (wd_expire) timeout <= 1'b1;
      end
      if (state_nxt == DONE)
        pass <= !wd_expire && (error_count == '0) && !mismatch;
    end else begin
      axis_tready <= 1'b0;
    end
  end

endmodule

// File: doc/axis_traffic_sink.md
Name: axis_traffic_sink

Overview:
AXI-Stream sink and checker that receives the streams generated by axis_traffic_gen, e.g. the mlp_1 collector output path. It drives tready with a selectable backpressure pattern and checks every accepted beat against an incrementing reference sequence. It also counts beats and mismatches, and reports pass/fail plus a stall timeout. It is a bench-side block but fully synthesizable, so it can be dropped into NoC endpoints for on-chip self-test.

Parameters:
DATA_WIDTH, 64, stream data width in bits
NUM_BEATS, 16, beats to accept per run (must be >= 1)
SEED, 0, expected value of the first beat
CNT_WIDTH, 32, width of beat/error counters
TIMEOUT, 1024, max consecutive RUN cycles with no handshake before abort (must be >= 1)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse; begins a run from IDLE or DONE
bp_mode  in  2  backpressure: 00 always ready, 01 alternate, 10 LFSR, 11 one-in-four
axis_tdata  in  DATA_WIDTH  stream data
axis_tvalid  in  1  stream valid
axis_tready  out  1  stream ready (registered)
beat_count  out  CNT_WIDTH  beats accepted in current/last run
error_count  out  CNT_WIDTH  mismatching beats in current/last run
first_err_idx  out  CNT_WIDTH  beat index of first mismatch
first_err_data  out  DATA_WIDTH  tdata of first mismatch
busy  out  1  high in RUN
done  out  1  high in DONE
timeout  out  1  run aborted by stall watchdog
pass  out  1  done & error_count==0 & !timeout

Behaviour:
- Reset (async, active-high) -> state IDLE. All outputs 0: axis_tready, counters, first_err_*, busy, done, timeout, pass. Internal expected value = SEED, LFSR = 16'hACE1, phase counter = 0, watchdog = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 -> RUN next cycle.
- DONE: start=1 -> RUN next cycle.
- On any entry to RUN: clear beat_count, error_count, first_err_*, timeout and watchdog; expected = SEED.
- RUN: start is ignored.
- axis_tready is a flop, never combinational from axis_tvalid. Its value is computed each cycle in RUN from bp_mode:
  - 00: 1
  - 01: toggles every cycle, first RUN cycle = 1
  - 10: LFSR[0]; 16-bit Fibonacci LFSR, taps 16,14,13,11, advances every RUN cycle
  - 11: 1 when the 2-bit phase counter == 0
- axis_tready is forced 0 in IDLE and DONE, and in the cycle after the final beat is accepted.
- Handshake = axis_tvalid & axis_tready on a rising edge. On each handshake:
  - beat_count += 1; expected += 1, wrapping mod 2^DATA_WIDTH.
  - If axis_tdata != expected: error_count += 1.
  - If that mismatch is the first of the run: first_err_idx = beat_count before increment; first_err_data = axis_tdata.
- Run end: the handshake that makes beat_count == NUM_BEATS moves the FSM to DONE next cycle. No further beats are accepted.
- Watchdog:
  - Increments each RUN cycle without a handshake; clears on every handshake.
  - Reaching TIMEOUT -> DONE with timeout=1.
  - Counts regardless of axis_tready, so a pattern that starves the stream also times out.
- Flag timing:
  - busy = (state==RUN).
  - done and pass are registered; both become valid in the first DONE cycle.
  - pass stays high until the next start or reset.
- Counters saturate at 2^CNT_WIDTH-1 and never wrap.
- Reset asserted mid-run aborts immediately to IDLE with reset values. No partial results are retained.
- A valid beat presented while tready=0 is not consumed and not checked. The source must hold it (AXI-S rule). This block does not check source stability.

Test Plan:
- bp_mode=00, gen sends 0..15 back-to-back, start pulse -> tready high from cycle after start; 16 beats in 16 cycles; done=1, pass=1, beat_count=16, error_count=0.
- bp_mode=01, same stream -> tready pattern 1,0,1,0...; 16 beats in 31-32 cycles; pass=1; no beat accepted while tready=0.
- Stream 0..15 with beat 5 corrupted to 0xDEAD -> error_count=1, first_err_idx=5, first_err_data=0xDEAD, pass=0.
- bp_mode=10, TIMEOUT=20, source tvalid held 0 -> after 20 idle RUN cycles done=1, timeout=1, pass=0, beat_count=0.
- Run 1 completes, then start again with SEED stream restarted -> counters cleared on RUN entry; second run pass=1, beat_count=16.
- Assert reset at beat 7 with bp_mode=11 -> all outputs 0 the same cycle (async); a new start after release runs a clean 16-beat check.
